// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// divider_pkg : shared types and constants for the 8b/4b restoring divider
// Revision    : 1.0
// ============================================================================
package divider_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int QUOTIENT_W = DIVIDEND_W - DIVISOR_W;
    localparam int TRIAL_W    = DIVISOR_W + 1;
    localparam int CNT_W      = $clog2(QUOTIENT_W);

    localparam logic [QUOTIENT_W-1:0] ERR_QUOTIENT = 4'hF;
    localparam logic [CNT_W-1:0]      CNT_START    = CNT_W'(QUOTIENT_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sub_5b.sv
`default_nettype none
// ============================================================================
// sub_5b   : 5-bit subtractor a - b built on a Kogge-Stone prefix carry tree
// Revision : 1.0
// ============================================================================
module sub_5b
    import divider_pkg::*;
(
    input  logic [TRIAL_W-1:0] a,
    input  logic [TRIAL_W-1:0] b,
    output logic [TRIAL_W-1:0] diff,
    output logic               borrow
);

    localparam int LEVELS = $clog2(TRIAL_W);

    logic [TRIAL_W-1:0]             w_b_n;
    logic [TRIAL_W-1:0]             w_half;
    logic [LEVELS:0][TRIAL_W-1:0]   w_g;
    logic [LEVELS:0][TRIAL_W-1:0]   w_p;
    logic                           w_unused_p;

    assign w_b_n  = ~b;
    assign w_half = a ^ w_b_n;

    // The +1 of two's complement enters as carry-in, folded into bit 0's generate.
    assign w_g[0] = (a & w_b_n) | {{(TRIAL_W-1){1'b0}}, w_half[0]};
    assign w_p[0] = w_half;

    generate
        for (genvar l = 0; l < LEVELS; l++) begin : g_level
            for (genvar i = 0; i < TRIAL_W; i++) begin : g_cell
                if (i >= (1 << l)) begin : g_merge
                    assign w_g[l+1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][i-(1<<l)]);
                    assign w_p[l+1][i] = w_p[l][i] & w_p[l][i-(1<<l)];
                end else begin : g_pass
                    assign w_g[l+1][i] = w_g[l][i];
                    assign w_p[l+1][i] = w_p[l][i];
                end
            end
        end
    endgenerate

    assign w_unused_p = ^w_p[LEVELS];

    assign diff   = w_half ^ {w_g[LEVELS][TRIAL_W-2:0], 1'b1};
    assign borrow = ~w_g[LEVELS][TRIAL_W-1];

endmodule
`default_nettype wire

// File: rtl/divider_8b_4b.sv
`default_nettype none
// ============================================================================
// divider_8b_4b : 8-bit by 4-bit unsigned restoring divider, one bit per cycle
// Revision      : 1.0
// ============================================================================
module divider_8b_4b
    import divider_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOTIENT_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero,
    output logic                  overflow
);

    state_t                  state_q, state_d;
    logic [QUOTIENT_W-1:0]   lo_q, lo_d;
    logic [DIVISOR_W-1:0]    divisor_q, divisor_d;
    logic [DIVISOR_W-1:0]    rem_q, rem_d;
    logic [QUOTIENT_W-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    div_zero_q, div_zero_d;
    logic                    overflow_q, overflow_d;

    logic                    w_in_div_zero;
    logic                    w_in_overflow;
    logic                    w_in_error;
    logic                    w_cur_bit;
    logic [TRIAL_W-1:0]      w_trial_a;
    logic [TRIAL_W-1:0]      w_trial_b;
    logic [TRIAL_W-1:0]      w_diff;
    logic                    w_borrow;
    logic                    w_unused_diff_msb;

    assign w_in_div_zero = (divisor == '0);
    assign w_in_overflow = !w_in_div_zero && (dividend[DIVIDEND_W-1:QUOTIENT_W] >= divisor);
    assign w_in_error    = w_in_div_zero || w_in_overflow;

    // Only the low nibble is kept; the high nibble seeds the partial remainder.
    assign w_cur_bit = lo_q[cnt_q];
    assign w_trial_a = {rem_q, w_cur_bit};
    assign w_trial_b = {1'b0, divisor_q};

    sub_5b u_sub (
        .a      (w_trial_a),
        .b      (w_trial_b),
        .diff   (w_diff),
        .borrow (w_borrow)
    );

    // Remainder stays below the divisor, so a successful trial never sets the MSB.
    assign w_unused_diff_msb = w_diff[TRIAL_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = w_in_error ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        quotient  = quo_q;
        remainder = rem_q;
        div_zero  = div_zero_q;
        overflow  = overflow_q;
    end

    always_comb begin
        lo_d       = lo_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        div_zero_d = div_zero_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    lo_d       = dividend[QUOTIENT_W-1:0];
                    divisor_d  = divisor;
                    div_zero_d = w_in_div_zero;
                    overflow_d = w_in_overflow;
                    if (w_in_error) begin
                        quo_d = ERR_QUOTIENT;
                        rem_d = dividend[DIVISOR_W-1:0];
                        cnt_d = '0;
                    end else begin
                        quo_d = '0;
                        rem_d = dividend[DIVIDEND_W-1:QUOTIENT_W];
                        cnt_d = CNT_START;
                    end
                end
            end
            CALC: begin
                quo_d[cnt_q] = ~w_borrow;
                rem_d        = w_borrow ? {rem_q[DIVISOR_W-2:0], w_cur_bit}
                                        : w_diff[DIVISOR_W-1:0];
                cnt_d        = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q       <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            lo_q       <= lo_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            div_zero_q <= div_zero_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_divider_8b_4b.sv
`default_nettype none
// ============================================================================
// tb_divider_8b_4b : scoreboard bench for the 8b/4b divider
// Revision         : 1.0
// ============================================================================
module tb_divider_8b_4b;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        logic       ov;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready_w;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;
    logic       overflow;

    logic       out_ready_dir;
    logic       bp_rand;
    logic       rnd_bit;

    int   checks;
    int   errors;
    exp_t sb[$];

    divider_8b_4b dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready_w),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    assign out_ready_w = bp_rand ? rnd_bit : out_ready_dir;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    function automatic exp_t mk(input logic [3:0] q, input logic [3:0] r,
                                input logic dz, input logic ov);
        exp_t e;
        e.q  = q;
        e.r  = r;
        e.dz = dz;
        e.ov = ov;
        return e;
    endfunction

    function automatic exp_t model(input logic [7:0] dd, input logic [3:0] dv);
        int qq;
        int rr;
        if (dv == 4'd0) return mk(4'hF, dd[3:0], 1'b1, 1'b0);
        if (dd[7:4] >= dv) return mk(4'hF, dd[3:0], 1'b0, 1'b1);
        qq = int'(dd) / int'(dv);
        rr = int'(dd) % int'(dv);
        return mk(qq[3:0], rr[3:0], 1'b0, 1'b0);
    endfunction

    // Monitor: every DONE cycle is compared with the oldest outstanding result.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid actual=1 required=0");
            end else begin
                chk("quotient",  int'(quotient),  int'(sb[0].q));
                chk("remainder", int'(remainder), int'(sb[0].r));
                chk("div_zero",  int'(div_zero),  int'(sb[0].dz));
                chk("overflow",  int'(overflow),  int'(sb[0].ov));
                chk("in_ready_in_done", int'(in_ready), 0);
                if (out_ready_w) void'(sb.pop_front());
            end
        end
    end

    // exp_lat > 0: measure edges to out_valid (accept edge counts as 1) and check the return to IDLE.
    task automatic do_op(input logic [7:0] dd, input logic [3:0] dv,
                         input exp_t e, input int exp_lat);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            fail_timeout("in_ready_wait");
            return;
        end
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (exp_lat > 0) begin
            n = 1;
            while (!out_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("latency", n, exp_lat);
            @(posedge clk); #1;
            chk("idle_after_handshake_out_valid", int'(out_valid), 0);
            chk("idle_after_handshake_in_ready",  int'(in_ready),  1);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        logic [7:0] dd;
        logic [3:0] dv;

        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        in_valid      = 1'b0;
        dividend      = '0;
        divisor       = '0;
        out_ready_dir = 1'b1;
        bp_rand       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready",  int'(in_ready),  1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_quotient",  int'(quotient),  0);
        chk("reset_remainder", int'(remainder), 0);
        chk("reset_div_zero",  int'(div_zero),  0);
        chk("reset_overflow",  int'(overflow),  0);
        rst = 1'b0;

        do_op(8'd200, 4'd13, mk(4'd15, 4'd5, 1'b0, 1'b0), 5);
        do_op(8'd100, 4'd7,  mk(4'd14, 4'd2, 1'b0, 1'b0), 5);
        do_op(8'd255, 4'd0,  mk(4'hF,  4'hF, 1'b1, 1'b0), 1);
        do_op(8'd240, 4'd15, mk(4'hF,  4'd0, 1'b0, 1'b1), 1);

        // Backpressure with operand and in_valid churn during CALC: 77/9 = 8 r 5.
        out_ready_dir = 1'b0;
        do_op(8'd77, 4'd9, mk(4'd8, 4'd5, 1'b0, 1'b0), 0);
        dividend = 8'hFF;
        divisor  = 4'd1;
        in_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        dividend = 8'h00;
        divisor  = 4'd0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) fail_timeout("bp_out_valid_wait");
        repeat (6) begin
            chk("bp_out_valid_held", int'(out_valid), 1);
            chk("bp_in_ready_low",   int'(in_ready),  0);
            @(posedge clk); #1;
        end
        out_ready_dir = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", int'(out_valid), 0);
        chk("bp_release_in_ready",  int'(in_ready),  1);

        // Reset during the second CALC cycle discards the operation.
        do_op(8'd200, 4'd13, mk(4'd15, 4'd5, 1'b0, 1'b0), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_back());
        chk("midcalc_rst_out_valid", int'(out_valid), 0);
        chk("midcalc_rst_in_ready",  int'(in_ready),  1);
        chk("midcalc_rst_quotient",  int'(quotient),  0);
        chk("midcalc_rst_remainder", int'(remainder), 0);
        chk("midcalc_rst_div_zero",  int'(div_zero),  0);
        chk("midcalc_rst_overflow",  int'(overflow),  0);
        repeat (8) @(posedge clk);
        #1;
        do_op(8'd9, 4'd3, mk(4'd3, 4'd0, 1'b0, 1'b0), 5);

        bp_rand = 1'b1;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                dd = 8'(a);
                dv = 4'(b);
                do_op(dd, dv, model(dd, dv), 0);
            end
        end
        bp_rand       = 1'b0;
        out_ready_dir = 1'b1;

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) fail_timeout("scoreboard_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
